// File: rtl/input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// input_conditioner_pkg
//   Shared defaults for the board input front end. The LED controller top and
//   its bench pull the same constants so switch/button widths and the debounce
//   window stay consistent across the design.
// ---------------------------------------------------------------------------
package input_conditioner_pkg;

    localparam int IC_N_SW            = 4;   // slide switches
    localparam int IC_N_BTN           = 4;   // push buttons
    localparam int IC_SYNC_STAGES     = 2;   // metastability flops per pin
    localparam int IC_DEBOUNCE_CYCLES = 16;  // stable cycles to accept a level

    // Counter width for a debounce window of d cycles (holds 0..d-1).
    function automatic int cnt_width(input int d);
        return (d <= 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
//   One raw pin -> synchroniser chain -> run-length filter -> stable level.
//   The stable level only flips after the synchronised input has disagreed
//   with it for DEBOUNCE_CYCLES consecutive cycles; any return to the stable
//   level restarts the run.
// Ports
//   clock       in   system clock
//   i_ck_reset  in   async active-low reset
//   i_raw       in   raw pin, asynchronous to clock
//   o_level     out  debounced level (flop)
//   o_accept    out  combinational: the level flips on the coming edge
// ---------------------------------------------------------------------------
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = IC_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = IC_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic i_ck_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_accept
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Lets the parent register change/press pulses in the same edge that
    // updates o_level, so they line up with the new level.
    assign o_accept = (s != o_level) && (cnt == LAST);

    always_ff @(posedge clock or negedge i_ck_reset) begin
        if (!i_ck_reset) begin
            sync_q  <= '0;
            cnt     <= '0;
            o_level <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
            if (s == o_level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                o_level <= s;
                cnt     <= '0;   // clears on accept, never wraps
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//   Board input front end: debounces switches and buttons and derives the
//   event signals the LED shift/flash controller consumes.
// Ports
//   clock        in   system clock, rising edge
//   i_ck_reset   in   async active-low reset
//   i_sw         in   [N_SW]  raw switch pins
//   i_btn        in   [N_BTN] raw button pins, active high
//   o_sw         out  [N_SW]  debounced switch levels
//   o_sw_change  out  1-cycle pulse, aligned with any o_sw update
//   o_btn        out  [N_BTN] debounced button levels
//   o_btn_press  out  [N_BTN] 1-cycle pulse on debounced rise, aligned with o_btn
//   o_btn_sel    out  [N_BTN] one-hot of last pressed button, 0 until first press
// ---------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_SW            = IC_N_SW,
    parameter int N_BTN           = IC_N_BTN,
    parameter int SYNC_STAGES     = IC_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = IC_DEBOUNCE_CYCLES
) (
    input  logic             clock,
    input  logic             i_ck_reset,
    input  logic [N_SW-1:0]  i_sw,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_SW-1:0]  o_sw,
    output logic             o_sw_change,
    output logic [N_BTN-1:0] o_btn,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_sel
);

    logic [N_SW-1:0]  sw_accept;
    logic [N_BTN-1:0] btn_accept;
    logic [N_BTN-1:0] sel_next;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock     (clock),
            .i_ck_reset(i_ck_reset),
            .i_raw     (i_sw[i]),
            .o_level   (o_sw[i]),
            .o_accept  (sw_accept[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock     (clock),
            .i_ck_reset(i_ck_reset),
            .i_raw     (i_btn[i]),
            .o_level   (o_btn[i]),
            .o_accept  (btn_accept[i])
        );
    end

    // Lowest-index press wins: scan high to low so the last hit is the lowest.
    always_comb begin
        sel_next = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (o_btn_press[i]) begin
                sel_next    = '0;
                sel_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge i_ck_reset) begin
        if (!i_ck_reset) begin
            o_sw_change <= 1'b0;
            o_btn_press <= '0;
            o_btn_sel   <= '0;
        end else begin
            // An accept always flips the level, so any accept is a change.
            o_sw_change <= |sw_accept;
            // Accept while the level is low is a rise; falls produce nothing.
            o_btn_press <= btn_accept & ~o_btn;
            if (|o_btn_press)
                o_btn_sel <= sel_next;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int S = 2;
    localparam int D = 4;

    logic       clock;
    logic       i_ck_reset;
    logic [3:0] i_sw, i_btn;
    logic [3:0] o_sw, o_btn, o_btn_press, o_btn_sel;
    logic       o_sw_change;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] samp[$];   // pins sampled on recent edges, {btn,sw}
    logic [7:0] shist[$];  // synchronised values seen by the filter, last D
    logic [3:0] m_sw, m_btn, m_press, m_sel;
    logic       m_change;

    input_conditioner #(
        .N_SW(4), .N_BTN(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock      (clock),
        .i_ck_reset (i_ck_reset),
        .i_sw       (i_sw),
        .i_btn      (i_btn),
        .o_sw       (o_sw),
        .o_sw_change(o_sw_change),
        .o_btn      (o_btn),
        .o_btn_press(o_btn_press),
        .o_btn_sel  (o_btn_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        samp.delete();
        shist.delete();
        m_sw = '0; m_btn = '0; m_press = '0; m_sel = '0; m_change = 1'b0;
    endtask

    // A level flips once the synchronised value has differed from it on each
    // of the last D edges; the sync chain is a pure S-edge delay.
    task automatic model_edge();
        logic [7:0] s, stab, nstab;
        bit all_diff;
        if (!i_ck_reset) begin
            model_clear();
        end else begin
            samp.push_back({i_btn, i_sw});
            if (samp.size() > S + 1) void'(samp.pop_front());
            s = (samp.size() > S) ? samp[0] : 8'h00;
            shist.push_back(s);
            if (shist.size() > D) void'(shist.pop_front());
            stab  = {m_btn, m_sw};
            nstab = stab;
            for (int b = 0; b < 8; b++) begin
                if (shist.size() == D) begin
                    all_diff = 1'b1;
                    foreach (shist[k]) if (shist[k][b] == stab[b]) all_diff = 1'b0;
                    if (all_diff) nstab[b] = ~stab[b];
                end
            end
            if (m_press != 4'd0) m_sel = m_press & (~m_press + 4'd1);
            m_change = |(nstab[3:0] ^ m_sw);
            m_press  = nstab[7:4] & ~m_btn;
            m_sw     = nstab[3:0];
            m_btn    = nstab[7:4];
        end
    endtask

    task automatic compare();
        chk("o_sw",        32'(o_sw),        32'(m_sw));
        chk("o_sw_change", 32'(o_sw_change), 32'(m_change));
        chk("o_btn",       32'(o_btn),       32'(m_btn));
        chk("o_btn_press", 32'(o_btn_press), 32'(m_press));
        chk("o_btn_sel",   32'(o_btn_sel),   32'(m_sel));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int h;
        model_clear();

        // 1: reset with switches high, then release
        i_ck_reset = 1'b0; i_sw = 4'b1111; i_btn = 4'b0000;
        #2;
        compare();
        chk("t1 rst outputs", 32'({o_sw, o_sw_change, o_btn, o_btn_press, o_btn_sel}), 32'd0);
        step_n(2);
        #6 i_ck_reset = 1'b1;
        step_n(5);
        chk("t1 sw not yet", 32'(o_sw), 32'h0);
        step();
        chk("t1 sw at 6", 32'(o_sw), 32'hf);
        chk("t1 change", 32'(o_sw_change), 32'h1);
        step();
        chk("t1 change once", 32'(o_sw_change), 32'h0);

        // 2: clean press and release
        i_btn = 4'b0001;
        step_n(5);
        chk("t2 btn not yet", 32'(o_btn), 32'h0);
        step();
        chk("t2 btn", 32'(o_btn), 32'h1);
        chk("t2 press", 32'(o_btn_press), 32'h1);
        step();
        chk("t2 press once", 32'(o_btn_press), 32'h0);
        chk("t2 sel", 32'(o_btn_sel), 32'h1);
        step_n(3);
        i_btn = 4'b0000;
        step_n(8);
        chk("t2 released", 32'(o_btn), 32'h0);

        // 3: bounce on btn[2], toggling every 20 ns, then settle high
        for (int t = 0; t < 4; t++) begin
            i_btn[2] = ~t[0];
            step_n(2);
            chk("t3 no change in bounce", 32'(o_btn), 32'h0);
        end
        i_btn[2] = 1'b1;
        step_n(5);
        chk("t3 press not yet", 32'(o_btn_press), 32'h0);
        step();
        chk("t3 press", 32'(o_btn_press), 32'h4);
        step();
        chk("t3 sel", 32'(o_btn_sel), 32'h4);

        // 4: simultaneous presses, lowest wins; then btn[3] alone
        i_btn = 4'b0000;
        step_n(8);
        i_btn = 4'b1001;
        step_n(6);
        chk("t4 press both", 32'(o_btn_press), 32'h9);
        step();
        chk("t4 sel lowest", 32'(o_btn_sel), 32'h1);
        i_btn = 4'b0000;
        step_n(8);
        i_btn = 4'b1000;
        step_n(7);
        chk("t4 sel btn3", 32'(o_btn_sel), 32'h8);

        // 5: switch change and a one-cycle glitch
        i_sw = 4'b1011;
        step_n(8);
        i_sw = 4'b0001;
        step_n(5);
        chk("t5 sw old", 32'(o_sw), 32'hb);
        step();
        chk("t5 sw new", 32'(o_sw), 32'h1);
        chk("t5 change", 32'(o_sw_change), 32'h1);
        step();
        chk("t5 change once", 32'(o_sw_change), 32'h0);
        i_sw = 4'b1001;
        step();
        i_sw = 4'b0001;
        step_n(8);
        chk("t5 glitch ignored", 32'(o_sw), 32'h1);

        // 6: reset two cycles into a btn[1] count
        i_btn = 4'b0000;
        step_n(8);
        i_btn = 4'b0010;
        step_n(S + 2);
        i_ck_reset = 1'b0;
        #1;
        model_clear();
        compare();
        chk("t6 rst outputs", 32'({o_sw, o_sw_change, o_btn, o_btn_press, o_btn_sel}), 32'd0);
        step();
        #2 i_ck_reset = 1'b1;
        step_n(5);
        chk("t6 press not yet", 32'(o_btn_press), 32'h0);
        step();
        chk("t6 press", 32'(o_btn_press), 32'h2);
        step();
        chk("t6 sel", 32'(o_btn_sel), 32'h2);

        // Random: bursts of pin flips with random hold lengths, one reset midway
        for (int r = 0; r < 120; r++) begin
            {i_btn, i_sw} = {i_btn, i_sw} ^ 8'($urandom);
            h = $urandom_range(1, 8);
            step_n(h);
            if (r == 60) begin
                i_ck_reset = 1'b0;
                #1;
                model_clear();
                compare();
                step();
                #2 i_ck_reset = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
